// File: rtl/bus_arbiter_pkg.sv
// Shared constants, FSM state type and a one-hot helper for the round-robin
// bus arbiter and its priority picker.
package bus_pkg;

  localparam int NODES      = 16;
  localparam int IDX_W      = 4;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 64;
  localparam int CRC_W      = 4;
  localparam int FRAME_BITS = ADDR_W + DATA_W + CRC_W;
  localparam int CNT_W      = 7;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  function automatic logic [NODES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NODES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant and frame-timing signals shared between the arbiter (master)
// and the stations plus serializer (slave).
interface bus_arbiter_if;
  import bus_pkg::*;

  logic [NODES-1:0] req;
  logic [NODES-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             bus_busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             frame_start;
  logic             frame_end;
  logic             frame_abort;

  modport master (
    input  req,
    output grant, grant_idx, bus_busy, bit_cnt,
    output frame_start, frame_end, frame_abort
  );

  modport slave (
    output req,
    input  grant, grant_idx, bus_busy, bit_cnt,
    input  frame_start, frame_end, frame_abort
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// priority pointer, wrapping modulo NODES.
module rr_pick
  import bus_pkg::*;
(
  input  logic [NODES-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_winner
);

  logic [NODES-1:0] w_rot;
  logic [IDX_W-1:0] w_enc;

  // Rotate so the pointer station lands at bit 0; index arithmetic wraps
  // because NODES is a power of two.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < NODES; i++) begin
      w_rot[i] = i_req[i_ptr + IDX_W'(i)];
    end
  end

  always_comb begin
    w_enc = '0;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_enc = IDX_W'(i);
      end
    end
  end

  assign o_valid  = |i_req;
  assign o_winner = i_ptr + w_enc;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter and frame sequencer: grants one station, times its
// frame bit by bit, enforces an inter-frame gap and rotates priority.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  bus_arbiter_if.master bus
);

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [NODES-1:0] r_grant;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_busy;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_start;
  logic             r_end;
  logic             r_abort;

  logic             w_valid;
  logic [IDX_W-1:0] w_winner;
  logic             w_req_win;
  logic             w_last;

  rr_pick u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  assign w_req_win = bus.req[r_grant_idx];
  assign w_last    = (r_bit_cnt == LAST_BIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gap_cnt   <= '0;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_busy      <= 1'b0;
      r_bit_cnt   <= '0;
      r_start     <= 1'b0;
      r_end       <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_end   <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant     <= onehot(w_winner);
            r_grant_idx <= w_winner;
            r_busy      <= 1'b1;
            r_bit_cnt   <= '0;
            r_start     <= 1'b1;
            r_state     <= SEND;
          end
        end
        SEND: begin
          // The last bit always completes, even if the request drops with it.
          if (w_last || !w_req_win) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_busy      <= 1'b0;
            r_bit_cnt   <= '0;
            r_end       <= w_last;
            r_abort     <= !w_last;
            r_ptr       <= r_grant_idx + IDX_W'(1);
            r_gap_cnt   <= '0;
            r_state     <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_idx   = r_grant_idx;
  assign bus.bus_busy    = r_busy;
  assign bus.bit_cnt     = r_bit_cnt;
  assign bus.frame_start = r_start;
  assign bus.frame_end   = r_end;
  assign bus.frame_abort = r_abort;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: single frame, contention, round-robin wrap,
// abort, last-bit drop and asynchronous reset in mid-frame.
module tb_bus_arbiter;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;
  logic [15:0] exp_g;

  bus_arbiter_if bus ();

  bus_arbiter #(.GAP_CYCLES(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_bus(input string tag, input logic [15:0] g, input logic [3:0] idx,
                            input logic busy, input logic [6:0] bc, input logic st,
                            input logic en, input logic ab);
    check({tag, ".grant"},       32'(bus.grant),       32'(g));
    check({tag, ".grant_idx"},   32'(bus.grant_idx),   32'(idx));
    check({tag, ".bus_busy"},    32'(bus.bus_busy),    32'(busy));
    check({tag, ".bit_cnt"},     32'(bus.bit_cnt),     32'(bc));
    check({tag, ".frame_start"}, 32'(bus.frame_start), 32'(st));
    check({tag, ".frame_end"},   32'(bus.frame_end),   32'(en));
    check({tag, ".frame_abort"}, 32'(bus.frame_abort), 32'(ab));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    bus.req = '0;
    repeat (2) @(posedge clock);
    #1;
    expect_bus("reset", 16'h0000, 4'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Single request: grant in cycle 1, bits 0..71, frame_end in cycle 73
    bus.req = 16'h0001;
    tick();
    expect_bus("single_grant", 16'h0001, 4'd0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 72; k++) begin
      tick();
      check("single_bitcnt", 32'(bus.bit_cnt), 32'(k));
      check("single_hold", 32'(bus.grant), 32'h0001);
    end
    tick();
    expect_bus("single_end", 16'h0000, 4'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
    bus.req = '0;
    tick();
    expect_bus("single_gap", 16'h0000, 4'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);

    // Contention between stations 0 and 1 from a fresh pointer
    do_reset();
    bus.req = 16'h0003;
    tick();
    expect_bus("cont_first", 16'h0001, 4'd0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0);
    repeat (71) tick();
    check("cont_bit71", 32'(bus.bit_cnt), 32'd71);
    tick();
    expect_bus("cont_end0", 16'h0000, 4'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
    bus.req = 16'h0002;
    tick();
    check("cont_gap1", 32'(bus.grant), 32'h0);
    tick();
    check("cont_gap2", 32'(bus.grant), 32'h0);
    tick();
    expect_bus("cont_second", 16'h0002, 4'd1, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0);
    repeat (71) tick();
    tick();
    expect_bus("cont_end1", 16'h0000, 4'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
    // Pointer now 2: stations 0 and 2 requesting must pick 2
    bus.req = 16'h0005;
    repeat (3) tick();
    expect_bus("ptr_is_2", 16'h0004, 4'd2, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0);
    bus.req = '0;
    tick();
    expect_bus("abort_bit0", 16'h0000, 4'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1);

    // Fairness: all stations requesting, order 0..15 then wrap to 0
    do_reset();
    bus.req = 16'hFFFF;
    tick();
    for (int n = 0; n < 16; n++) begin
      exp_g = 16'h0001 << n;
      expect_bus("rr_grant", exp_g, 4'(n), 1'b1, 7'd0, 1'b1, 1'b0, 1'b0);
      repeat (72) tick();
      check("rr_end", 32'(bus.frame_end), 32'd1);
      repeat (3) tick();
    end
    expect_bus("rr_wrap", 16'h0001, 4'd0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0);
    bus.req = 16'h0021;
    repeat (72) tick();
    check("rr_wrap_end", 32'(bus.frame_end), 32'd1);

    // Abort of station 5 at bit 10
    bus.req = 16'h0020;
    repeat (3) tick();
    expect_bus("abort_grant", 16'h0020, 4'd5, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    check("abort_bit10", 32'(bus.bit_cnt), 32'd10);
    bus.req = '0;
    tick();
    expect_bus("abort", 16'h0000, 4'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
    bus.req = 16'h0041;
    repeat (3) tick();
    expect_bus("ptr_is_6", 16'h0040, 4'd6, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0);

    // Request drops in the last-bit cycle: completion, not abort
    repeat (71) tick();
    check("lastbit_cnt", 32'(bus.bit_cnt), 32'd71);
    bus.req = '0;
    tick();
    expect_bus("lastbit_drop", 16'h0000, 4'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in mid-frame
    bus.req = 16'h0004;
    repeat (3) tick();
    expect_bus("rst_grant", 16'h0004, 4'd2, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0);
    repeat (30) tick();
    check("rst_bit30", 32'(bus.bit_cnt), 32'd30);
    #2;
    reset_n = 1'b0;
    #1;
    expect_bus("async_reset", 16'h0000, 4'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    bus.req = 16'h8000;
    @(posedge clock);
    #1;
    expect_bus("reset_held", 16'h0000, 4'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();
    expect_bus("after_reset", 16'h8000, 4'd15, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
